// File: rtl/neopixel_frame_arb.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_frame_arb
// Purpose  : Frame-atomic two-source arbiter in front of a NeoPixel TX FIFO.
//            A granted source streams pixels straight into the FIFO. The
//            transmitter runs only after the whole frame is buffered, and a
//            fixed idle gap follows before the next grant.
// Options  : NEO_FRAME_CNT_EN adds frame_cnt_o, a wrapping count of sent frames.
// Revision : 1.0  initial release
// ============================================================================
module neopixel_frame_arb #(
   parameter int MAX_PIXELS = 1023,
   parameter int GAP_CYCLES = 1200
) (
   input  logic        clk_20MHz_i,
   input  logic        neo_rst_i,
   input  logic        src0_valid_i,
   input  logic [23:0] src0_rgb_i,
   input  logic        src0_last_i,
   output logic        src0_ready_o,
   input  logic        src1_valid_i,
   input  logic [23:0] src1_rgb_i,
   input  logic        src1_last_i,
   output logic        src1_ready_o,
   input  logic        fifo_full_flg_i,
   input  logic        fifo_empty_flg_i,
   output logic        wr_en_o,
   output logic [23:0] neo_rgb_o,
   output logic        neo_msgTyp_o,
   output logic        neo_tx_enable_o,
   output logic        owner_o,
   output logic        busy_o
`ifdef NEO_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt_o
`endif
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_XFER  = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_GAP   = 2'd3;

   localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
   localparam logic [9:0]         c_PIX_LAST = 10'(MAX_PIXELS - 1);

   logic [1:0]         r_state;
   logic               r_owner;
   logic               r_last_served;
   logic [9:0]         r_pix_cnt;
   logic [c_GAP_W-1:0] r_gap_cnt;
   logic               r_tx_en;

   logic               w_own_valid;
   logic               w_own_last;
   logic [23:0]        w_own_rgb;
   logic               w_xfer;
   logic               w_ready;
   logic               w_accept;
   logic               w_eof;

   // Owner-selected view of the two source ports
   assign w_own_valid = r_owner ? src1_valid_i : src0_valid_i;
   assign w_own_last  = r_owner ? src1_last_i  : src0_last_i;
   assign w_own_rgb   = r_owner ? src1_rgb_i   : src0_rgb_i;

   // Handshake and zero-latency FIFO write path; end of frame is the source's
   // own last flag or the pixel limit, whichever comes first
   assign w_xfer   = (r_state == c_XFER);
   assign w_ready  = w_xfer & ~fifo_full_flg_i;
   assign w_accept = w_ready & w_own_valid;
   assign w_eof    = w_xfer & (w_own_last | (r_pix_cnt == c_PIX_LAST));

   assign src0_ready_o    = w_ready & ~r_owner;
   assign src1_ready_o    = w_ready &  r_owner;
   assign wr_en_o         = w_accept;
   assign neo_rgb_o       = w_own_rgb;
   assign neo_msgTyp_o    = w_eof;
   assign neo_tx_enable_o = r_tx_en;
   assign owner_o         = r_owner;
   assign busy_o          = (r_state != c_IDLE);

   // Arbitration FSM: grant, buffer the frame, transmit, then hold off for the gap.
   // last_served resets to 1 so that source 0 wins the first tie.
   always_ff @(posedge clk_20MHz_i or negedge neo_rst_i) begin
      if (!neo_rst_i) begin
         r_state       <= c_IDLE;
         r_owner       <= 1'b0;
         r_last_served <= 1'b1;
         r_pix_cnt     <= 10'd0;
         r_gap_cnt     <= '0;
         r_tx_en       <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (src0_valid_i | src1_valid_i) begin
                  r_owner   <= (src0_valid_i & src1_valid_i) ? ~r_last_served : src1_valid_i;
                  r_pix_cnt <= 10'd0;
                  r_state   <= c_XFER;
               end
            end
            c_XFER: begin
               if (w_accept) begin
                  if (w_eof) begin
                     r_state <= c_DRAIN;
                     r_tx_en <= 1'b1;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + 10'd1;
                  end
               end
            end
            c_DRAIN: begin
               if (fifo_empty_flg_i) begin
                  r_state   <= c_GAP;
                  r_tx_en   <= 1'b0;
                  r_gap_cnt <= '0;
               end
            end
            c_GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_state       <= c_IDLE;
                  r_last_served <= r_owner;
               end else begin
                  r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

`ifdef NEO_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Count frames whose transmission completed (DRAIN -> GAP), wrapping at 16 bits
   always_ff @(posedge clk_20MHz_i or negedge neo_rst_i) begin
      if (!neo_rst_i) begin
         r_frame_cnt <= 16'd0;
      end else if ((r_state == c_DRAIN) && fifo_empty_flg_i) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_cnt_o = r_frame_cnt;
`endif

endmodule
`default_nettype wire
